// File: rtl/sram16_wb32_pkg.sv
// Shared definitions for Wishbone32 responders: FSM states, wait-state limit,
// bus widths and the SRAM strobe bundle used by sram16_wb32.
package sram16_wb32_pkg;

    localparam int unsigned WAIT_STATES_MAX = 7;
    localparam int unsigned CNT_W           = 3;
    localparam int unsigned WB_ADR_W        = 17;
    localparam int unsigned WB_DAT_W        = 32;
    localparam int unsigned WB_SEL_W        = 4;
    localparam int unsigned SRAM_ADR_W      = 18;
    localparam int unsigned SRAM_DAT_W      = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_ACK  = 2'd3
    } wb_state_t;

    typedef struct packed {
        logic ce_n;
        logic oe_n;
        logic we_n;
        logic ub_n;
        logic lb_n;
        logic dat_oe;
    } sram_ctl_t;

    localparam sram_ctl_t SRAM_CTL_IDLE = '{
        ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1, ub_n: 1'b1, lb_n: 1'b1, dat_oe: 1'b0
    };

    // Strobes for one active 16-bit half; lanes = {upper byte, lower byte} enables.
    function automatic sram_ctl_t half_ctl(input logic we, input logic [1:0] lanes);
        sram_ctl_t c;
        c.ce_n   = 1'b0;
        c.oe_n   = we;
        c.we_n   = ~we;
        c.ub_n   = ~lanes[1];
        c.lb_n   = ~lanes[0];
        c.dat_oe = we;
        return c;
    endfunction

endpackage

// File: rtl/sram16_wb32_timer.sv
// Wait-state down-counter: load at the start of a half, done when it reaches zero.
module sram16_wb32_timer
    import sram16_wb32_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             count,
    output logic             done_c
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (count && cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign done_c = (cnt == '0);

endmodule

// File: rtl/sram16_wb32.sv
// Wishbone B4 pipelined 32-bit responder over a 16-bit asynchronous SRAM (low half, then high half).
// Define SRAM16_WB32_SKIP_EN to skip any half whose two byte enables are both clear.
module sram16_wb32
    import sram16_wb32_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic                  I_clk,
    input  logic                  I_reset,
    input  logic                  I_wb_cyc,
    input  logic                  I_wb_stb,
    input  logic                  I_wb_we,
    input  logic [WB_ADR_W-1:0]   I_wb_adr,
    input  logic [WB_DAT_W-1:0]   I_wb_dat,
    input  logic [WB_SEL_W-1:0]   I_wb_sel,
    output logic [WB_DAT_W-1:0]   O_wb_dat,
    output logic                  O_wb_ack,
    output logic                  O_wb_stall,
    output logic [SRAM_ADR_W-1:0] O_sram_adr,
    output logic [SRAM_DAT_W-1:0] O_sram_dat,
    input  logic [SRAM_DAT_W-1:0] I_sram_dat,
    output logic                  O_sram_dat_oe,
    output logic                  O_sram_ce_n,
    output logic                  O_sram_oe_n,
    output logic                  O_sram_we_n,
    output logic                  O_sram_ub_n,
    output logic                  O_sram_lb_n
);

    localparam logic [CNT_W-1:0] WS =
        CNT_W'((WAIT_STATES > WAIT_STATES_MAX) ? WAIT_STATES_MAX : WAIT_STATES);

`ifdef SRAM16_WB32_SKIP_EN
    localparam bit SKIP_EN = 1'b1;
`else
    localparam bit SKIP_EN = 1'b0;
`endif

    wb_state_t             state;
    sram_ctl_t             ctl;
    logic [WB_ADR_W-1:0]   adr_q;
    logic [WB_DAT_W-1:0]   dat_q;
    logic [WB_SEL_W-1:0]   sel_q;
    logic                  we_q;
    logic                  abort;
    logic                  accept_c;
    logic                  load_c;
    logic                  count_c;
    logic                  done_c;

    assign accept_c = (state == ST_IDLE) && I_wb_cyc && I_wb_stb;
    assign load_c   = accept_c || ((state == ST_LO) && done_c);
    assign count_c  = (state == ST_LO) || (state == ST_HI);

    sram16_wb32_timer u_timer (
        .clk      (I_clk),
        .rst      (I_reset),
        .load     (load_c),
        .load_val (WS),
        .count    (count_c),
        .done_c   (done_c)
    );

    // Strobes come straight from registers so reset releases them asynchronously.
    assign O_sram_ce_n   = ctl.ce_n;
    assign O_sram_oe_n   = ctl.oe_n;
    assign O_sram_we_n   = ctl.we_n;
    assign O_sram_ub_n   = ctl.ub_n;
    assign O_sram_lb_n   = ctl.lb_n;
    assign O_sram_dat_oe = ctl.dat_oe;

    always_ff @(posedge I_clk or posedge I_reset) begin
        if (I_reset) begin
            state      <= ST_IDLE;
            ctl        <= SRAM_CTL_IDLE;
            adr_q      <= '0;
            dat_q      <= '0;
            sel_q      <= '0;
            we_q       <= 1'b0;
            abort      <= 1'b0;
            O_wb_ack   <= 1'b0;
            O_wb_stall <= 1'b0;
            O_wb_dat   <= '0;
            O_sram_adr <= '0;
            O_sram_dat <= '0;
        end else begin
            O_wb_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept_c) begin
                        adr_q      <= I_wb_adr;
                        dat_q      <= I_wb_dat;
                        sel_q      <= I_wb_sel;
                        we_q       <= I_wb_we;
                        abort      <= 1'b0;
                        O_wb_stall <= 1'b1;
                        if (I_wb_sel == '0) begin
                            state    <= ST_ACK;
                            O_wb_ack <= 1'b1;
                        end else if (SKIP_EN && I_wb_sel[1:0] == 2'b00) begin
                            state      <= ST_HI;
                            ctl        <= half_ctl(I_wb_we, I_wb_sel[3:2]);
                            O_sram_adr <= {I_wb_adr, 1'b1};
                            O_sram_dat <= I_wb_dat[31:16];
                        end else begin
                            state      <= ST_LO;
                            ctl        <= half_ctl(I_wb_we, I_wb_sel[1:0]);
                            O_sram_adr <= {I_wb_adr, 1'b0};
                            O_sram_dat <= I_wb_dat[15:0];
                        end
                    end
                end
                ST_LO: begin
                    if (!I_wb_cyc) abort <= 1'b1;
                    if (done_c) begin
                        if (!we_q) O_wb_dat[15:0] <= I_sram_dat;
                        if (abort || !I_wb_cyc) begin
                            state      <= ST_IDLE;
                            ctl        <= SRAM_CTL_IDLE;
                            O_wb_stall <= 1'b0;
                        end else if (SKIP_EN && sel_q[3:2] == 2'b00) begin
                            state    <= ST_ACK;
                            ctl      <= SRAM_CTL_IDLE;
                            O_wb_ack <= 1'b1;
                        end else begin
                            state      <= ST_HI;
                            ctl        <= half_ctl(we_q, sel_q[3:2]);
                            O_sram_adr <= {adr_q, 1'b1};
                            O_sram_dat <= dat_q[31:16];
                        end
                    end
                end
                ST_HI: begin
                    if (!I_wb_cyc) abort <= 1'b1;
                    if (done_c) begin
                        if (!we_q) O_wb_dat[31:16] <= I_sram_dat;
                        ctl <= SRAM_CTL_IDLE;
                        if (abort || !I_wb_cyc) begin
                            state      <= ST_IDLE;
                            O_wb_stall <= 1'b0;
                        end else begin
                            state    <= ST_ACK;
                            O_wb_ack <= 1'b1;
                        end
                    end
                end
                ST_ACK: begin
                    state      <= ST_IDLE;
                    O_wb_stall <= 1'b0;
                end
                default: begin
                    state      <= ST_IDLE;
                    ctl        <= SRAM_CTL_IDLE;
                    O_wb_stall <= 1'b0;
                end
            endcase
        end
    end

endmodule
